// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared decode-sequencing types: sequencer state encoding, opcode constants
// and an instruction view used by the core and its control blocks.
package pipe_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        WAIT_OP = 3'd1,
        ADV     = 3'd2,
        DRAIN   = 3'd3,
        HALTED  = 3'd4
    } seq_state_e;

    localparam logic [5:0] OPC_HALT_DEF  = 6'b010001;
    localparam logic [5:0] OPC_MULTI_DEF = 6'b011100;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] payload;
    } dec_inst_t;

    function automatic logic [5:0] inst_opcode(input logic [31:0] inst);
        dec_inst_t inst_s;
        inst_s = dec_inst_t'(inst);
        return inst_s.opcode;
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl.sv
// Decode-stage sequencer: freezes the front end for multi-cycle external
// operations and for the halt drain, and keeps retire/cycle statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; detects OPC_MULTI / OPC_HALT in decode
// WAIT_OP | external operation in flight, timeout counter running
// ADV     | one cycle letting the frozen decode instruction advance
// DRAIN   | back-end pipeline emptying after a halt
// HALTED  | core stopped until reset
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [5:0]  OPC_HALT     = OPC_HALT_DEF,
    parameter logic [5:0]  OPC_MULTI    = OPC_MULTI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dec_inst,
    input  logic        dec_valid,
    input  logic        opr_finished,
    output logic        stall,
    output logic        op_start,
    output logic        halted,
    output logic        op_err,
    output logic [31:0] retire_cnt,
    output logic [31:0] cycle_cnt
);

    // Down-counter load values; terminal count is zero, so load N-1 for N cycles.
    localparam logic [31:0] TIMEOUT_LD = (TIMEOUT == 0)      ? 32'd0 : 32'(TIMEOUT - 1);
    localparam logic [31:0] DRAIN_LD   = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

    seq_state_e  state_q, state_d;
    logic [31:0] seq_cnt_q, seq_cnt_d;
    logic [5:0]  opcode;
    logic        is_multi;
    logic        is_halt;
    logic        enter_wait;
    logic        err_set;
    logic        unused_payload;

    assign opcode         = inst_opcode(dec_inst);
    assign unused_payload = ^dec_inst[25:0];
    assign is_multi       = dec_valid && (opcode == OPC_MULTI);
    assign is_halt        = dec_valid && (opcode == OPC_HALT);

    always_comb begin
        state_d    = state_q;
        seq_cnt_d  = seq_cnt_q;
        stall      = 1'b0;
        enter_wait = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            RUN: begin
                if (is_multi) begin
                    stall      = 1'b1;
                    enter_wait = 1'b1;
                    seq_cnt_d  = TIMEOUT_LD;
                    state_d    = WAIT_OP;
                end else if (is_halt) begin
                    stall     = 1'b1;
                    seq_cnt_d = DRAIN_LD;
                    state_d   = DRAIN;
                end
            end
            WAIT_OP: begin
                stall = 1'b1;
                // Completion takes priority over a timeout in the same cycle.
                if (opr_finished) begin
                    seq_cnt_d = '0;
                    state_d   = ADV;
                end else if (seq_cnt_q == '0) begin
                    err_set = 1'b1;
                    state_d = ADV;
                end else begin
                    seq_cnt_d = seq_cnt_q - 32'd1;
                end
            end
            ADV: begin
                state_d = RUN;
            end
            DRAIN: begin
                stall = 1'b1;
                if (seq_cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    seq_cnt_d = seq_cnt_q - 32'd1;
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            seq_cnt_q  <= '0;
            op_start   <= 1'b0;
            halted     <= 1'b0;
            op_err     <= 1'b0;
            retire_cnt <= '0;
            cycle_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            op_start  <= enter_wait;
            if (err_set) begin
                op_err <= 1'b1;
            end
            if (state_d == HALTED) begin
                halted <= 1'b1;
            end
            if (dec_valid && !stall) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (state_q != HALTED) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: directed corner cases plus random
// instruction streams scored per transaction against arithmetic expectations.
module tb_pipe_seq_ctrl;

    localparam int         DRAIN    = 4;
    localparam int         TMO      = 8;
    localparam logic [5:0] OP_HALT  = 6'b010001;
    localparam logic [5:0] OP_MULTI = 6'b011100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dec_inst = '0;
    logic        dec_valid = 1'b0;
    logic        opr_finished = 1'b0;
    logic        stall, op_start, halted, op_err;
    logic [31:0] retire_cnt, cycle_cnt;

    pipe_seq_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_inst    (dec_inst),
        .dec_valid   (dec_valid),
        .opr_finished(opr_finished),
        .stall       (stall),
        .op_start    (op_start),
        .halted      (halted),
        .op_err      (op_err),
        .retire_cnt  (retire_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_retire = '0;
    logic [31:0] exp_cycles = '0;
    logic        exp_err = 1'b0;
    logic        s_stall, s_op_start, s_halted, s_op_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] plain_inst();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63)); while (op == OP_HALT || op == OP_MULTI);
        return {op, 26'($urandom)};
    endfunction

    // One clock: drive inputs, sample at the falling edge, return just after the rising edge.
    task automatic cyc(input logic [31:0] inst, input logic v, input logic fin);
        dec_inst     = inst;
        dec_valid    = v;
        opr_finished = fin;
        @(negedge clk);
        s_stall    = stall;
        s_op_start = op_start;
        s_halted   = halted;
        s_op_err   = op_err;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_retire"}, retire_cnt, exp_retire);
        chk({tag, "_cycles"}, cycle_cnt, exp_cycles);
    endtask

    task automatic do_reset();
        dec_valid    = 1'b0;
        opr_finished = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_retire = '0;
        exp_cycles = '0;
        exp_err    = 1'b0;
    endtask

    task automatic t_normal();
        cyc(plain_inst(), 1'b1, 1'($urandom_range(0, 1)));
        chk("normal_stall", 32'(s_stall), 32'd0);
        exp_retire++;
        exp_cycles++;
    endtask

    task automatic t_bubble();
        cyc($urandom, 1'b0, 1'($urandom_range(0, 1)));
        chk("bubble_stall", 32'(s_stall), 32'd0);
        exp_cycles++;
    endtask

    // lat = cycles between op_start and opr_finished; beyond TMO the op never finishes.
    task automatic t_multi(input int lat);
        logic [31:0] inst;
        int w, st, os, os_idx;
        logic err;
        w      = (lat + 1 <= TMO) ? lat + 1 : TMO;
        err    = (lat + 1 > TMO);
        inst   = {OP_MULTI, 26'($urandom)};
        st     = 0;
        os     = 0;
        os_idx = -1;
        cyc(inst, 1'b1, 1'($urandom_range(0, 1)));
        if (s_stall) st++;
        if (s_op_start) os++;
        for (int i = 1; i <= w; i++) begin
            cyc(inst, 1'b1, (i == lat + 1));
            if (s_stall) st++;
            if (s_op_start) begin
                os++;
                if (os_idx < 0) os_idx = i;
            end
        end
        cyc(inst, 1'b1, 1'($urandom_range(0, 1)));
        chk("adv_stall", 32'(s_stall), 32'd0);
        if (s_op_start) os++;
        if (err) exp_err = 1'b1;
        chk("multi_op_err", 32'(s_op_err), 32'(exp_err));
        chk("multi_stall_cycles", 32'(st), 32'(1 + w));
        chk("op_start_pulses", 32'(os), 32'd1);
        chk("op_start_cycle", 32'(os_idx), 32'd1);
        exp_retire++;
        exp_cycles += 32'(w + 2);
        check_counters("multi");
    endtask

    task automatic t_halt(input logic [31:0] inst);
        int hi, st;
        logic [31:0] cyc_frozen, ret_frozen;
        hi = 0;
        st = 0;
        cyc(inst, 1'b1, 1'($urandom_range(0, 1)));
        chk("halt_detect_stall", 32'(s_stall), 32'd1);
        if (s_halted) hi++;
        for (int i = 1; i <= DRAIN; i++) begin
            cyc($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (s_halted) hi++;
            if (s_stall) st++;
        end
        cyc($urandom, 1'b1, 1'b1);
        chk("halted_rise", 32'(s_halted), 32'd1);
        chk("halted_early", 32'(hi), 32'd0);
        chk("drain_stall_cycles", 32'(st), 32'(DRAIN));
        exp_cycles += 32'(1 + DRAIN);
        check_counters("halt");
        ret_frozen = exp_retire;
        cyc_frozen = exp_cycles;
        st = 0;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            cyc($urandom, 1'b1, 1'b1);
            if (s_stall) st++;
            if (s_halted) hi++;
        end
        chk("halted_sticky", 32'(hi), 32'd3);
        chk("halted_stall", 32'(st), 32'd3);
        chk("halted_op_err", 32'(op_err), 32'(exp_err));
        chk("frozen_cycles", cycle_cnt, cyc_frozen);
        chk("frozen_retire", retire_cnt, ret_frozen);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_op_start"}, 32'(op_start), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_op_err"}, 32'(op_err), 32'd0);
        chk({tag, "_retire"}, retire_cnt, 32'd0);
        chk({tag, "_cycles"}, cycle_cnt, 32'd0);
    endtask

    task automatic t_reset_mid_drain();
        cyc({OP_HALT, 26'($urandom)}, 1'b1, 1'b0);
        cyc($urandom, 1'b1, 1'b0);
        cyc($urandom, 1'b1, 1'b0);
        dec_valid    = 1'b0;
        opr_finished = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("rst_drain");
        @(posedge clk);
        #1 reset = 1'b0;
        exp_retire = '0;
        exp_cycles = '0;
        exp_err    = 1'b0;
    endtask

    task automatic t_reset_mid_wait();
        logic [31:0] inst;
        inst = {OP_MULTI, 26'($urandom)};
        cyc(inst, 1'b1, 1'b0);
        cyc(inst, 1'b1, 1'b0);
        cyc(inst, 1'b1, 1'b0);
        dec_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("rst_wait");
        @(posedge clk);
        #1 reset = 1'b0;
        exp_retire = '0;
        exp_cycles = '0;
        exp_err    = 1'b0;
        for (int i = 0; i < 12; i++) cyc($urandom, 1'b0, 1'b1);
        exp_cycles += 32'd12;
        chk("late_finish_stall", 32'(s_stall), 32'd0);
        chk("late_finish_op_start", 32'(s_op_start), 32'd0);
        chk("late_finish_op_err", 32'(op_err), 32'd0);
        check_counters("late_finish");
    endtask

    initial begin
        #3 reset = 1'b1;
        #2 check_all_zero("reset");
        dec_inst  = {OP_MULTI, 26'd0};
        dec_valid = 1'b1;
        #1 chk("reset_stall_multi", 32'(stall), 32'd1);
        dec_inst = {OP_HALT, 26'd0};
        #1 chk("reset_stall_halt", 32'(stall), 32'd1);
        dec_valid = 1'b0;
        #1 chk("reset_stall_idle", 32'(stall), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        repeat (3) t_normal();
        t_halt(32'h4400_0000);
        chk("three_retired", retire_cnt, 32'd3);
        do_reset();

        t_multi(5);
        t_multi(0);
        t_multi(TMO - 1);
        chk("tie_no_err", 32'(op_err), 32'd0);
        t_multi(100);
        t_normal();
        t_multi(2);
        chk("op_err_sticky", 32'(op_err), 32'd1);
        do_reset();

        t_reset_mid_drain();
        repeat (3) t_normal();
        t_bubble();
        check_counters("after_rst");
        t_reset_mid_wait();
        do_reset();

        for (int e = 0; e < 6; e++) begin
            int n;
            n = $urandom_range(10, 25);
            for (int k = 0; k < n; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4) t_normal();
                else if (r < 6) t_bubble();
                else t_multi($urandom_range(0, 11));
            end
            check_counters("epoch");
            if ($urandom_range(0, 2) == 0) t_reset_mid_drain();
            else t_halt({OP_HALT, 26'($urandom)});
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4: pipeline stages behind decode that must empty on halt.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT_OP cycles before error.
REQ-003 SHALL have parameter OPC_HALT, default 6'b010001: halt opcode.
REQ-004 SHALL have parameter OPC_MULTI, default 6'b011100: multi-cycle external-operation opcode.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port dec_inst, input, 32: instruction in the decode stage; opcode = [31:26].
REQ-008 SHALL have port dec_valid, input, 1: dec_inst is a real instruction.
REQ-009 SHALL have port opr_finished, input, 1: external unit completed the issued operation.
REQ-010 SHALL have port stall, output, 1: freezes fetch and decode.
REQ-011 SHALL have port op_start, output, 1: one-cycle pulse that launches the external operation.
REQ-012 SHALL have port halted, output, 1: core has stopped; sticky.
REQ-013 SHALL have port op_err, output, 1: operation timeout; sticky.
REQ-014 SHALL have port retire_cnt, output, 32: instructions that left decode.
REQ-015 SHALL have port cycle_cnt, output, 32: cycles spent outside HALTED.

Function
REQ-016 SHALL implement states RUN, WAIT_OP, ADV, DRAIN and HALTED.
REQ-017 SHALL, in RUN with dec_valid and opcode OPC_MULTI, assert stall combinationally, go to WAIT_OP next edge, and pulse op_start (registered) in the first WAIT_OP cycle.
REQ-018 SHALL, in RUN with dec_valid and opcode OPC_HALT, assert stall combinationally and go to DRAIN.
REQ-019 SHALL hold stall=1 in WAIT_OP, DRAIN and HALTED; stall=0 in ADV; stall=0 in RUN unless REQ-017 or REQ-018 applies.
REQ-020 SHALL sample opr_finished only in WAIT_OP, including the op_start cycle; opr_finished in any other state is ignored.
REQ-021 SHALL go from WAIT_OP to ADV on opr_finished; ADV lasts one cycle, lets the decode instruction advance regardless of opcode, then returns to RUN.
REQ-022 SHALL count WAIT_OP cycles from 1; if the count reaches TIMEOUT without opr_finished, set op_err and go to ADV. When opr_finished and timeout occur in the same cycle, opr_finished wins and op_err stays clear.
REQ-023 SHALL, in DRAIN, count DRAIN_CYCLES cycles, then enter HALTED.
REQ-024 SHALL assert halted on the first HALTED cycle; HALTED is left only by reset.
REQ-025 SHALL increment retire_cnt by 1 in every cycle with dec_valid=1 and stall=0. The halt instruction is not counted.
REQ-026 SHALL increment cycle_cnt every cycle the state is not HALTED.
REQ-027 SHALL let both counters wrap modulo 2^32 silently.
REQ-028 SHALL treat dec_valid=0 in RUN as a bubble: no transition, no count.

Reset
REQ-029 SHALL, on reset assertion and asynchronously, force: state RUN, op_start 0, halted 0, op_err 0, retire_cnt 0, cycle_cnt 0, and all internal counters 0.
REQ-030 SHALL, on reset in mid WAIT_OP or DRAIN, abandon the operation; a later opr_finished has no effect.
REQ-031 SHALL drive stall from state and inputs only, so stall=0 during reset unless decode holds OPC_MULTI or OPC_HALT with dec_valid.

Structure
REQ-032 SHALL take the state enum and the OPC_HALT and OPC_MULTI opcode constants from the shared struct package used by the core.
REQ-033 SHALL be a single module; the WAIT_OP timeout counter and DRAIN counter SHALL share one internal counter, with no sub-module.

Verification
REQ-034 SHALL cover: three valid non-special instructions then halt 0x44000000 -> retire_cnt=3; halted rises exactly DRAIN_CYCLES+1 cycles after halt enters decode; cycle_cnt then freezes.
REQ-035 SHALL cover: OPC_MULTI in decode, opr_finished 5 cycles after op_start -> op_start high exactly 1 cycle; stall high 6 cycles plus the detect cycle; one ADV cycle; retire_cnt +1.
REQ-036 SHALL cover: OPC_MULTI with opr_finished never asserted, TIMEOUT=8 -> op_err=1 after 8 WAIT_OP cycles; ADV follows; op_err remains 1 afterwards.
REQ-037 SHALL cover: opr_finished in the same cycle as op_start -> WAIT_OP lasts 1 cycle, then ADV.
REQ-038 SHALL cover: reset asserted in the 3rd DRAIN cycle -> all outputs zero immediately; after release, a new instruction stream retires normally.
REQ-039 SHALL cover: stray opr_finished pulses while in RUN and HALTED -> no state change, no op_err.
